register_bank: RTL and testbench

//   Parametrised multi-register storage for the CPU datapath; successor to the single bus register.

---
 rtl/regbank_pkg.sv | 17 +
 rtl/regbank_read_port.sv | 45 ++++
 rtl/register_bank.sv | 117 +++++++++++
 tb/tb_register_bank.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types, defaults and address helper for the register bank.
// Build option REGBANK_BYPASS_EN is consumed by regbank_read_port.
package regbank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;

    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regbank_read_port.sv
// Registered read port: address mux, zero forcing, and optional write-through.
// Defining REGBANK_BYPASS_EN forwards a committing same-cycle write to this port.
module regbank_read_port
    import regbank_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ZERO_REG0 = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             busy,
    input  logic             zero_force,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] mem [DEPTH],
`ifdef REGBANK_BYPASS_EN
    input  logic             wr_commit,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
`endif
    output logic [WIDTH-1:0] rd_data
);

    logic force_zero;

    assign force_zero = zero_force || busy
                     || !addr_valid(32'(rd_addr), int'(DEPTH))
                     || ((ZERO_REG0 != 0) && (rd_addr == '0));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            rd_data <= '0;
        end else if (force_zero) begin
            rd_data <= '0;
`ifdef REGBANK_BYPASS_EN
        end else if (wr_commit && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
`endif
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/register_bank.sv
// Multi-register bank: one write port, two registered read ports, and a wipe sweeper.
// Optional same-cycle write forwarding is enabled with REGBANK_BYPASS_EN.
//
// state    | meaning
// ST_IDLE  | normal operation, writes and reads honoured, wipe accepted
// ST_SWEEP | zeroing one entry per cycle, writes dropped, reads return 0
module register_bank
    import regbank_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ZERO_REG0 = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             wipe,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic             ba_zero_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             busy
);

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    logic [AW-1:0]    idx;
    logic             wr_commit;

    assign busy = (state == ST_SWEEP);

    assign wr_commit = wr_en && (state == ST_IDLE)
                    && addr_valid(32'(wr_addr), int'(DEPTH))
                    && !((ZERO_REG0 != 0) && (wr_addr == '0));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wipe) begin
                        state <= ST_SWEEP;
                        idx   <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (idx == AW'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Commit and sweep never coincide: commits require ST_IDLE.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == ST_SWEEP) begin
            mem[idx] <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    regbank_read_port #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ZERO_REG0 (ZERO_REG0)
    ) u_port_a (
        .clock      (clock),
        .clear_n    (clear_n),
        .busy       (busy),
        .zero_force (ba_zero_a),
        .rd_addr    (rd_addr_a),
        .mem        (mem),
`ifdef REGBANK_BYPASS_EN
        .wr_commit  (wr_commit),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`endif
        .rd_data    (rd_data_a)
    );

    regbank_read_port #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ZERO_REG0 (ZERO_REG0)
    ) u_port_b (
        .clock      (clock),
        .clear_n    (clear_n),
        .busy       (busy),
        .zero_force (1'b0),
        .rd_addr    (rd_addr_b),
        .mem        (mem),
`ifdef REGBANK_BYPASS_EN
        .wr_commit  (wr_commit),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`endif
        .rd_data    (rd_data_b)
    );

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench: a 16-entry and a 12-entry bank share stimulus and are checked
// against an array-based reference model of the bank's observable behaviour.
module tb_register_bank;

`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        wipe = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  rd_addr_a = '0;
    logic        ba_zero_a = 1'b0;
    logic [3:0]  rd_addr_b = '0;

    logic [31:0] a16, b16, a12, b12;
    logic        busy16, busy12;

    int n_assert = 0;
    int n_fail = 0;
    int stepno = 0;

    int          dep [2] = '{16, 12};
    logic [31:0] mdl [2][16];
    int          left [2];

    always #5 clock = ~clock;

    register_bank #(.WIDTH(32), .DEPTH(16), .ZERO_REG0(1)) dut16 (
        .clock(clock), .clear_n(clear_n), .wipe(wipe), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a),
        .ba_zero_a(ba_zero_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a16), .rd_data_b(b16), .busy(busy16)
    );

    register_bank #(.WIDTH(32), .DEPTH(12), .ZERO_REG0(1)) dut12 (
        .clock(clock), .clear_n(clear_n), .wipe(wipe), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a),
        .ba_zero_a(ba_zero_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a12), .rd_data_b(b12), .busy(busy12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=0x%08h expected=0x%08h", tag, stepno, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            left[k] = 0;
            for (int i = 0; i < 16; i++) mdl[k][i] = '0;
        end
    endtask

    function automatic logic [31:0] model_read(int k, logic [3:0] a, logic bsy,
                                               logic commit, logic [3:0] wa, logic [31:0] wd);
        if (bsy || int'(a) >= dep[k] || a == 4'd0) return 32'd0;
        if (BYP && commit && wa == a) return wd;
        return mdl[k][a];
    endfunction

    task automatic check_outputs(input string tag, input logic [31:0] ea [2],
                                 input logic [31:0] eb [2], input logic ebusy [2]);
        chk({tag, " d16 rd_a"}, a16, ea[0]);
        chk({tag, " d16 rd_b"}, b16, eb[0]);
        chk({tag, " d16 busy"}, 32'(busy16), 32'(ebusy[0]));
        chk({tag, " d12 rd_a"}, a12, ea[1]);
        chk({tag, " d12 rd_b"}, b12, eb[1]);
        chk({tag, " d12 busy"}, 32'(busy12), 32'(ebusy[1]));
    endtask

    task automatic step(input logic wp, input logic we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] ra, input logic ba,
                        input logic [3:0] rb);
        logic [31:0] ea [2];
        logic [31:0] eb [2];
        logic        eby [2];
        logic        bsy, commit;
        @(negedge clock);
        stepno++;
        wipe = wp; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; ba_zero_a = ba; rd_addr_b = rb;
        for (int k = 0; k < 2; k++) begin
            bsy    = (left[k] > 0);
            commit = !bsy && we && (int'(wa) < dep[k]) && (wa != 4'd0);
            ea[k]  = ba ? 32'd0 : model_read(k, ra, bsy, commit, wa, wd);
            eb[k]  = model_read(k, rb, bsy, commit, wa, wd);
            if (commit) mdl[k][wa] = wd;
            if (bsy) begin
                mdl[k][dep[k] - left[k]] = '0;
                left[k]--;
            end else if (wp) begin
                left[k] = dep[k];
            end
            eby[k] = (left[k] > 0);
        end
        @(posedge clock);
        #1;
        check_outputs("step", ea, eb, eby);
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 4'd0, 32'd0, 4'(a), 1'b0, 4'(15 - a));
    endtask

    task automatic fill();
        for (int a = 1; a < 16; a++) step(1'b0, 1'b1, 4'(a), 32'(a) * 32'h0101_0101, 4'(a), 1'b0, 4'(a - 1));
    endtask

    task automatic check_reset_zero();
        logic [31:0] z [2];
        logic        zb [2];
        z  = '{32'd0, 32'd0};
        zb = '{1'b0, 1'b0};
        check_outputs("reset", z, z, zb);
    endtask

    initial begin
        model_reset();
        clear_n = 1'b0;
        #12;
        check_reset_zero();
        @(negedge clock);
        clear_n = 1'b1;

        // write r5, read it back next cycle
        step(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd5, 1'b0, 4'd5);

        // r0 is hardwired zero; ba_zero_a masks port A only
        step(1'b0, 1'b1, 4'd0, 32'h0000_1234, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd5, 1'b1, 4'd5);

        // same-cycle write and read of r3
        step(1'b0, 1'b1, 4'd3, 32'h0000_0011, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd3, 32'hAAAA_5555, 4'd3, 1'b0, 4'd3);
        step(1'b0, 1'b1, 4'd3, 32'hAAAA_5555, 4'd3, 1'b1, 4'd3);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd3, 1'b0, 4'd3);

        // randomized traffic with occasional wipes
        repeat (300) begin
            step($urandom_range(0, 24) == 0, 1'($urandom), 4'($urandom), $urandom,
                 4'($urandom), $urandom_range(0, 3) == 0, 4'($urandom));
        end
        repeat (20) step(1'b0, 1'b0, 4'd0, 32'd0, 4'($urandom), 1'b0, 4'($urandom));

        // full sweep; writes, reads and re-wipes while busy
        fill();
        step(1'b1, 1'b1, 4'd7, 32'h0BAD_F00D, 4'd7, 1'b0, 4'd1);
        for (int i = 0; i < 17; i++) begin
            step(i == 4, 1'b1, 4'($urandom_range(1, 15)), $urandom,
                 4'($urandom_range(1, 15)), 1'b0, 4'($urandom_range(1, 15)));
        end
        read_all();

        // reset mid-sweep aborts it and leaves the bank zero
        fill();
        step(1'b1, 1'b0, 4'd0, 32'd0, 4'd1, 1'b0, 4'd2);
        repeat (7) step(1'b0, 1'b0, 4'd0, 32'd0, 4'd9, 1'b0, 4'd11);
        @(negedge clock);
        #2;
        clear_n = 1'b0;
        #1;
        model_reset();
        check_reset_zero();
        @(negedge clock);
        clear_n = 1'b1;
        read_all();

        // out-of-range address on the 12-entry bank
        step(1'b0, 1'b1, 4'd13, 32'h0000_0077, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd13, 1'b0, 4'd13);
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
